// File: rtl/mips_mem_pkg.sv
// Shared definitions for the wait-state data-memory responder: word width,
// responder FSM states, the misaligned-access poison word and the legal
// LATENCY range.
package mips_mem_pkg;

  localparam int WORD_W      = 32;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  localparam logic [WORD_W-1:0] POISON_WORD = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Counter preload for a given latency. An out-of-range latency is clamped
  // into the legal window, so the counter can never wrap.
  function automatic logic [3:0] ctr_load_val(input int lat);
    int l;
    l = lat;
    if (l < LATENCY_MIN) l = LATENCY_MIN;
    if (l > LATENCY_MAX) l = LATENCY_MAX;
    return 4'(l - 1);
  endfunction

endpackage

// File: rtl/dmem_latency_ctr.sv
// 4-bit load/decrement counter that times the wait states of one memory
// request. done_o flags the last wait cycle (count == 1).
module dmem_latency_ctr
  import mips_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: a load takes precedence over a decrement, and the count
  // never decrements below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == 4'd1);

endmodule

// File: rtl/dmem_wait_responder.sv
// Word-addressed data RAM that answers a MIPS core's data port after a
// programmable number of wait states. A request is accepted in IDLE, waits
// in WAIT, and completes with a one-cycle ready pulse in RESP.
//
// Handshake: the core holds memread/memwrite (plus dataadr/writedata) high
// until it samples ready=1; the responder accepts only in IDLE, so a request
// still held during RESP is taken again in the following IDLE cycle.
//
// Optional build macro DMEM_ALIGN_CHECK_EN adds the 'misaligned' output:
// requests with dataadr[1:0] != 0 still complete after LATENCY cycles, but
// their RAM write is suppressed and they return the poison word.
module dmem_wait_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic              misaligned,
`endif
  output logic              ready,
  output logic [1:0]        dbg_state
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD_VAL = ctr_load_val(LATENCY);

  dmem_state_t       state_q;
  logic              ready_q;
  logic [WORD_W-1:0] readdata_q;
  logic [IDX_W-1:0]  idx_q;
  logic              op_write_q;
  logic              mis_cap_q;

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx_in;
  logic              req_in;
  logic              mis_in;
  logic              accept;
  logic              mem_we;
  logic              ctr_done;
  logic [3:0]        ctr_cnt_unused;
  logic              unused_addr_bits;

  assign idx_in = dataadr[IDX_W+1:2];
  assign req_in = memread | memwrite;
  assign accept = (state_q == IDLE) && req_in && !rst;

`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  assign mis_in           = (dataadr[1:0] != 2'b00);
  assign unused_addr_bits = ^dataadr[ADDR_W-1:IDX_W+2];
  assign misaligned       = mis_q;
`else
  assign mis_in           = 1'b0;
  assign unused_addr_bits = ^{dataadr[ADDR_W-1:IDX_W+2], dataadr[1:0]};
`endif

  // Writes commit on the acceptance edge; a misaligned write never lands.
  assign mem_we = accept && memwrite && !mis_in;

  // Data returned in RESP: poison for a misaligned request, the RAM word for
  // an aligned read, and the previous value for an aligned write.
  function automatic logic [WORD_W-1:0] resp_word(input logic is_write,
                                                  input logic is_mis,
                                                  input logic [WORD_W-1:0] ram_word,
                                                  input logic [WORD_W-1:0] held);
    if (is_mis)        return POISON_WORD;
    else if (!is_write) return ram_word;
    else                return held;
  endfunction

  dmem_latency_ctr u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (LOAD_VAL),
    .dec_i      (state_q == WAIT),
    .cnt_o      (ctr_cnt_unused),
    .done_o     (ctr_done)
  );

  // RAM array: not reset, written only when a request is accepted.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_in] <= writedata;
    end
  end

  // Responder FSM with registered ready/readdata/misaligned outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      readdata_q <= '0;
      idx_q      <= '0;
      op_write_q <= 1'b0;
      mis_cap_q  <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_in) begin
            idx_q      <= idx_in;
            op_write_q <= memwrite;
            mis_cap_q  <= mis_in;
            if (LATENCY <= 1) begin
              state_q    <= RESP;
              ready_q    <= 1'b1;
              readdata_q <= resp_word(memwrite, mis_in, mem_q[idx_in], readdata_q);
`ifdef DMEM_ALIGN_CHECK_EN
              mis_q      <= mis_in;
`endif
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ctr_done) begin
            state_q    <= RESP;
            ready_q    <= 1'b1;
            readdata_q <= resp_word(op_write_q, mis_cap_q, mem_q[idx_q], readdata_q);
`ifdef DMEM_ALIGN_CHECK_EN
            mis_q      <= mis_cap_q;
`endif
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign readdata  = readdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench for dmem_wait_responder: directed vector table,
// hand-written multi-cycle sequences (held request, reset mid-read,
// optional alignment check) and randomized traffic against an array model.
`timescale 1ns/1ps
module tb_dmem_wait_responder;

  localparam int DEPTH   = 64;
  localparam int LAT     = 2;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic [1:0]  dbg_state;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: plain word array plus the last value a read returned.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_rd;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  dmem_wait_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .ADDR_W      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .memread    (memread),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
`ifdef DMEM_ALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .ready      (ready),
    .dbg_state  (dbg_state)
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign misaligned = 1'b0;
`endif

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) & (DEPTH - 1));
  endfunction

  // Driver: present one request, wait for ready, then release the port.
  // lat is the number of edges from acceptance to the edge that samples ready.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rdv, output logic mis, output logic pulse_ok);
    lat = 0;
    rdv = '0;
    mis = 1'b0;
    @(posedge clk); #1;
    memread = rd; memwrite = wr; dataadr = addr; writedata = wd;
    @(posedge clk);
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n;
        rdv = readdata;
        mis = misaligned;
        break;
      end
      @(posedge clk);
    end
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    pulse_ok = !ready;
  endtask

  // Update the model for one request and return the readdata the core should see.
  function automatic logic [31:0] model_req(input logic rd, input logic wr,
                                            input logic [31:0] addr, input logic [31:0] wd);
    logic bad;
    bad = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    bad = (addr[1:0] != 2'b00);
`endif
    if (bad) begin
      last_rd = 32'hDEADBEEF;
    end else if (wr) begin
      mem_m[widx(addr)] = wd;
    end else if (rd) begin
      last_rd = mem_m[widx(addr)];
    end
    return last_rd;
  endfunction

  initial begin
    int          lat;
    logic [31:0] rdv;
    logic        mis;
    logic        pok;
    logic [31:0] d;
    logic [31:0] a;
    logic        r;
    logic        w;
    logic [31:0] e;
    int          gap;

    rst = 1'b1; memread = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: no ready, readdata cleared.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, ready}, 32'h0);
      check("idle_rdata", readdata, 32'h0);
    end
    check("idle_state", {30'b0, dbg_state}, 32'h0);

    // Fill every word so later reads are defined.
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      do_req(1'b0, 1'b1, 32'(i * 4), d, lat, rdv, mis, pok);
      void'(model_req(1'b0, 1'b1, 32'(i * 4), d));
    end
    check("init_rdata_held", readdata, 32'h0);

    // Directed vectors.
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0001_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h0001_0000};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0001_0000};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_1234, 32'hA5A5_A5A5};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_1234};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         32'h0001_0000};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 32'h0001_0000};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_000F, 32'h0,         32'hDEAD_BEEF};
`else
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_000F, 32'h0,         32'hCAFE_F00D};
`endif
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'h89AB_CDEF, vecs[8].exp_rdata};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_01FC, 32'h0,         32'h89AB_CDEF};

    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdv, mis, pok);
      void'(model_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_rdata", i), rdv, vecs[i].exp_rdata);
      check($sformatf("vec%0d_pulse", i), {31'b0, pok}, 32'h1);
    end

    // Held read: a request left asserted through RESP is taken in the next
    // IDLE, so ready pulses recur every LAT+1 cycles.
    @(posedge clk); #1;
    memread = 1'b1; dataadr = 32'h4;
    gap = 0;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    check("held_first_rdata", readdata, 32'h0001_0000);
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      if (ready) begin gap = n; break; end
    end
    memread = 1'b0;
    check("held_gap", 32'(gap), 32'(LAT + 1));
    check("held_second_rdata", readdata, 32'h0001_0000);
    last_rd = 32'h0001_0000;

    // Reset while a read of 0x0C is waiting.
    @(posedge clk); #1;
    memread = 1'b1; dataadr = 32'hC;
    @(posedge clk);
    #1 rst = 1'b1; memread = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_state", {30'b0, dbg_state}, 32'h0);
    check("rst_mid_ready", {31'b0, ready}, 32'h0);
    check("rst_mid_rdata", readdata, 32'h0);
    rst = 1'b0;
    last_rd = '0;
    gap = 0;
    for (int n = 0; n < 2 * LAT + 2; n++) begin
      @(negedge clk);
      if (ready) gap++;
    end
    check("rst_dropped_ready", 32'(gap), 32'h0);
    do_req(1'b1, 1'b0, 32'hC, 32'h0, lat, rdv, mis, pok);
    e = model_req(1'b1, 1'b0, 32'hC, 32'h0);
    check("rst_after_latency", 32'(lat), 32'(LAT));
    check("rst_after_rdata", rdv, e);

`ifdef DMEM_ALIGN_CHECK_EN
    // Misaligned write is dropped; misaligned read returns poison.
    do_req(1'b0, 1'b1, 32'hD, 32'h1111_2222, lat, rdv, mis, pok);
    void'(model_req(1'b0, 1'b1, 32'hD, 32'h1111_2222));
    check("mis_wr_flag", {31'b0, mis}, 32'h1);
    check("mis_wr_latency", 32'(lat), 32'(LAT));
    do_req(1'b1, 1'b0, 32'hC, 32'h0, lat, rdv, mis, pok);
    void'(model_req(1'b1, 1'b0, 32'hC, 32'h0));
    check("mis_word_kept", rdv, 32'hCAFE_F00D);
    check("mis_aligned_flag", {31'b0, mis}, 32'h0);
    do_req(1'b1, 1'b0, 32'hD, 32'h0, lat, rdv, mis, pok);
    void'(model_req(1'b1, 1'b0, 32'hD, 32'h0));
    check("mis_rd_rdata", rdv, 32'hDEAD_BEEF);
    check("mis_rd_flag", {31'b0, mis}, 32'h1);
    @(negedge clk);
    check("mis_flag_clears", {31'b0, misaligned}, 32'h0);
`endif

    // Randomized traffic through the scoreboard.
    for (int i = 0; i < 150; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      a = 32'($urandom_range(0, 1023));
`ifdef DMEM_ALIGN_CHECK_EN
      a[1:0] = 2'b00;
`endif
      d = $urandom;
      exp_q.push_back(model_req(r, w, a, d));
      do_req(r, w, a, d, lat, rdv, mis, pok);
      e = exp_q.pop_front();
      check("rand_rdata", rdv, e);
      check("rand_latency", 32'(lat), 32'(LAT));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
